// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code sequencer.
//   - FSM state enum for prefix sequencing (scan-code set 2).
//   - Prefix bytes, discard list, Pause replacement code.
//   - Modifier base codes and their bit positions in the mods vector.
//   - Key event struct {ext, brk, code} (10 bits).
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXTBRK,
    PAUSE
  } ps2_state_t;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_E1 = 8'hE1;
  localparam logic [7:0] PFX_F0 = 8'hF0;

  // The Pause key sends E1 followed by 7 more bytes and has no break code;
  // the whole sequence is reported as a single extended 77 make.
  localparam logic [7:0] CODE_PAUSE = 8'h77;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam logic [7:0] MC_LSHIFT = 8'h12;
  localparam logic [7:0] MC_RSHIFT = 8'h59;
  localparam logic [7:0] MC_CTRL   = 8'h14;  // plain: lctrl, E0: rctrl
  localparam logic [7:0] MC_ALT    = 8'h11;  // plain: lalt,  E0: ralt

  localparam logic [2:0] MOD_LSHIFT = 3'd0;
  localparam logic [2:0] MOD_RSHIFT = 3'd1;
  localparam logic [2:0] MOD_LCTRL  = 3'd2;
  localparam logic [2:0] MOD_RCTRL  = 3'd3;
  localparam logic [2:0] MOD_LALT   = 3'd4;
  localparam logic [2:0] MOD_RALT   = 3'd5;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Last emitted make, used by the optional typematic filter.
  typedef struct packed {
    logic       valid;
    logic       ext;
    logic [7:0] code;
  } ps2_make_t;

  // Keyboard status/acknowledge bytes that never form part of a key event.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // Returns the modifier vector after applying one key event.
  function automatic logic [5:0] mod_update(input logic [5:0] m, input ps2_evt_t e);
    logic [5:0] r;
    logic       hit;
    logic [2:0] idx;
    r   = m;
    hit = 1'b0;
    idx = MOD_LSHIFT;
    if (!e.ext) begin
      case (e.code)
        MC_LSHIFT: begin hit = 1'b1; idx = MOD_LSHIFT; end
        MC_RSHIFT: begin hit = 1'b1; idx = MOD_RSHIFT; end
        MC_CTRL:   begin hit = 1'b1; idx = MOD_LCTRL;  end
        MC_ALT:    begin hit = 1'b1; idx = MOD_LALT;   end
        default:   hit = 1'b0;
      endcase
    end else begin
      case (e.code)
        MC_CTRL: begin hit = 1'b1; idx = MOD_RCTRL; end
        MC_ALT:  begin hit = 1'b1; idx = MOD_RALT;  end
        default: hit = 1'b0;
      endcase
    end
    if (hit) r[idx] = !e.brk;
    return r;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: generic show-ahead synchronous FIFO.
//   clk, rst_n         clock, async active-low reset
//   push, wr_data      write request/data (accepted when not full, or when
//                      a pop happens in the same cycle)
//   pop                read request (ignored when empty)
//   rd_data            head entry; holds the last popped value when empty
//   full, empty, count occupancy status
// DEPTH must be a power of two (pointers wrap naturally).
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A pop frees the slot the simultaneous push needs, even when full.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  // When empty, keep presenting the entry that was last at the head.
  assign rd_data = empty ? last_q : mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it has been written, and the empty case reads last_q instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// ps2_scan_sequencer: turns raw PS/2 set-2 scan-code bytes into key events
// {ext, brk, code}, tracks modifier keys and queues events in a FIFO.
//   clk, rst_n              clock, async active-low reset
//   ps2_code_new, ps2_code  byte strobe and data from the PS/2 receiver
//   evt_valid/evt_ready     handshake for the head event
//   evt_code/evt_ext/evt_brk head event fields
//   mods                    {ralt, lalt, rctrl, lctrl, rshift, lshift}
//   overflow, clr_overflow  sticky event-drop flag and its clear
// Optional: define PS2_TYPEMATIC_FILTER_EN to drop repeated makes of the
// key that was last pressed (auto-repeat suppression).
module ps2_scan_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_code_new,
  input  logic [7:0] ps2_code,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic [5:0] mods,
  output logic       overflow,
  input  logic       clr_overflow
);
  import ps2_pkg::*;

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state_q, state_d, cur_state;
  logic [2:0]       skip_q, skip_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [5:0]       mods_q, mods_d;
  logic             overflow_q, overflow_d;
  ps2_evt_t         new_evt, head_evt;
  logic             emit, push, pop, timeout;
  logic             fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;  // occupancy not needed here
`ifdef PS2_TYPEMATIC_FILTER_EN
  ps2_make_t        last_q, last_d;
`endif

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    mods_d     = mods_q;
    emit       = 1'b0;
    new_evt    = '0;
    push       = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    last_d     = last_q;
`endif

    // An abandoned sequence behaves as IDLE in the very cycle it expires,
    // so a byte arriving then starts fresh.
    timeout   = (state_q != IDLE) && (tmo_q == TMO_LAST);
    cur_state = timeout ? IDLE : state_q;
    if (timeout) state_d = IDLE;

    if (ps2_code_new) begin
      case (cur_state)
        IDLE: begin
          if (ps2_code == PFX_E0)      state_d = EXT;
          else if (ps2_code == PFX_F0) state_d = BRK;
          else if (ps2_code == PFX_E1) begin
            state_d = PAUSE;
            skip_d  = PAUSE_SKIP;
          end else if (!is_discard(ps2_code)) begin
            emit    = 1'b1;
            new_evt = '{ext: 1'b0, brk: 1'b0, code: ps2_code};
          end
        end
        EXT: begin
          if (ps2_code == PFX_F0) state_d = EXTBRK;
          else begin
            emit    = 1'b1;
            new_evt = '{ext: 1'b1, brk: 1'b0, code: ps2_code};
            state_d = IDLE;
          end
        end
        BRK: begin
          emit    = 1'b1;
          new_evt = '{ext: 1'b0, brk: 1'b1, code: ps2_code};
          state_d = IDLE;
        end
        EXTBRK: begin
          emit    = 1'b1;
          new_evt = '{ext: 1'b1, brk: 1'b1, code: ps2_code};
          state_d = IDLE;
        end
        PAUSE: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == 3'd1) begin
            emit    = 1'b1;
            new_evt = '{ext: 1'b1, brk: 1'b0, code: CODE_PAUSE};
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    push = emit;
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (timeout) last_d = '0;
    if (emit) begin
      if (new_evt.brk) last_d = '0;
      else if (last_d.valid && last_d.ext == new_evt.ext && last_d.code == new_evt.code)
        push = 1'b0;
      else last_d = '{valid: 1'b1, ext: new_evt.ext, code: new_evt.code};
    end
`endif

    // Modifiers follow every accepted event, even if the FIFO drops it.
    if (push) mods_d = mod_update(mods_q, new_evt);

    tmo_d = (ps2_code_new || state_d == IDLE) ? '0 : tmo_q + 1'b1;

    pop        = !fifo_empty && evt_ready;
    overflow_d = (overflow_q && !clr_overflow) || (push && fifo_full && !pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      skip_q     <= '0;
      tmo_q      <= '0;
      mods_q     <= '0;
      overflow_q <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      mods_q     <= mods_d;
      overflow_q <= overflow_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_q     <= last_d;
`endif
    end
  end

  ps2_evt_fifo #(
    .WIDTH ($bits(ps2_evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (new_evt),
    .pop     (pop),
    .rd_data (head_evt),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head_evt.code;
  assign evt_ext   = head_evt.ext;
  assign evt_brk   = head_evt.brk;
  assign mods      = mods_q;
  assign overflow  = overflow_q;

endmodule
